// File: rtl/obuf_tag_req_arbiter.sv
// Round-robin arbiter sharing one obuf tag-request port among NUM_REQ requesters.
// Define OBUF_TAG_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest) with identical timing.
module obuf_tag_req_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned REQ_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned TAG_W     = 1,
    parameter int unsigned ISSUE_GAP = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_reuse,
    input  logic [NUM_REQ-1:0] req_bias_prev_sw,
    input  logic [NUM_REQ-1:0] req_ddr_pe_sw,
    input  logic [NUM_REQ-1:0] req_block_done,
    output logic [NUM_REQ-1:0] req_ack,
    output logic [TAG_W-1:0]   ack_tag,
    output logic               tag_req,
    output logic               tag_reuse,
    output logic               tag_bias_prev_sw,
    output logic               tag_ddr_pe_sw,
    output logic               block_done,
    input  logic               tag_ready,
    input  logic [TAG_W-1:0]   tag,
    output logic               busy
);

    localparam int unsigned      CNT_W    = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(ISSUE_GAP - 1);
    localparam logic [REQ_W-1:0] LAST_IDX = REQ_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, ACK} state_t;

    // Returns {found, index}: first set bit of vec scanning upward from start, wrapping.
    function automatic logic [REQ_W:0] pick(input logic [NUM_REQ-1:0] vec,
                                            input logic [REQ_W-1:0]   start);
        logic [REQ_W:0]   res;
        logic [REQ_W-1:0] idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = REQ_W'((int'(start) + k) % NUM_REQ);
            if (vec[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [REQ_W-1:0] next_idx(input logic [REQ_W-1:0] w);
        return (w == LAST_IDX) ? '0 : w + REQ_W'(1);
    endfunction

    state_t             state;
    logic [REQ_W-1:0]   winner;
    logic [CNT_W-1:0]   gap_cnt;
    logic [NUM_REQ-1:0] pending_done;

    logic [REQ_W-1:0]   idle_start;
    logic [REQ_W-1:0]   ack_start;
    logic [NUM_REQ-1:0] winner_oh;
    logic [REQ_W:0]     idle_pick;
    logic [REQ_W:0]     ack_pick_ex;
    logic [REQ_W:0]     ack_pick_in;
    logic [REQ_W:0]     done_pick;
    logic               done_fire;
    logic               idle_issue;
    logic               ack_issue;
    logic [NUM_REQ-1:0] done_clr;
    logic [REQ_W-1:0]   next_sel;

`ifdef OBUF_TAG_ARB_FIXED_PRIO_EN
    assign idle_start = '0;
    assign ack_start  = '0;
`else
    logic [REQ_W-1:0] rr_ptr;

    assign idle_start = rr_ptr;
    assign ack_start  = next_idx(winner);
`endif

    assign winner_oh = NUM_REQ'(1) << winner;
    assign busy      = (state != IDLE) || (|pending_done);

    always_comb begin
        idle_pick   = pick(req_valid, idle_start);
        ack_pick_ex = pick(req_valid & ~winner_oh, ack_start);
        ack_pick_in = pick(req_valid, ack_start);
        done_pick   = pick(pending_done & ~req_valid, '0);

        done_fire  = (state == IDLE) && tag_ready && done_pick[REQ_W];
        idle_issue = (state == IDLE) && tag_ready && !done_pick[REQ_W] && idle_pick[REQ_W];
        // The acked requester's valid is still its old request, so issue straight from ACK
        // only when the choice does not depend on that bit and no block_done is waiting.
        ack_issue  = (state == ACK) && tag_ready && (pending_done == '0) &&
                     ack_pick_ex[REQ_W] && (ack_pick_ex == ack_pick_in);

        done_clr = done_fire ? (NUM_REQ'(1) << done_pick[REQ_W-1:0]) : '0;
        next_sel = (state == ACK) ? ack_pick_ex[REQ_W-1:0] : idle_pick[REQ_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            winner           <= '0;
            gap_cnt          <= '0;
            pending_done     <= '0;
            req_ack          <= '0;
            ack_tag          <= '0;
            tag_req          <= 1'b0;
            tag_reuse        <= 1'b0;
            tag_bias_prev_sw <= 1'b0;
            tag_ddr_pe_sw    <= 1'b0;
            block_done       <= 1'b0;
`ifndef OBUF_TAG_ARB_FIXED_PRIO_EN
            rr_ptr           <= '0;
`endif
        end else begin
            tag_req      <= 1'b0;
            req_ack      <= '0;
            ack_tag      <= '0;
            block_done   <= done_fire;
            // A fresh pulse wins over a same-cycle clear so it is never lost.
            pending_done <= (pending_done & ~done_clr) | req_block_done;

`ifndef OBUF_TAG_ARB_FIXED_PRIO_EN
            if (state == ACK) rr_ptr <= next_idx(winner);
`endif

            if (idle_issue || ack_issue) begin
                winner           <= next_sel;
                tag_reuse        <= req_reuse[next_sel];
                tag_bias_prev_sw <= req_bias_prev_sw[next_sel];
                tag_ddr_pe_sw    <= req_ddr_pe_sw[next_sel];
                tag_req          <= 1'b1;
                state            <= ISSUE;
            end else begin
                case (state)
                    IDLE: ;
                    ISSUE: begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end
                    GAP: begin
                        if (gap_cnt == '0) begin
                            req_ack <= winner_oh;
                            ack_tag <= tag;
                            state   <= ACK;
                        end else begin
                            gap_cnt <= gap_cnt - CNT_W'(1);
                        end
                    end
                    ACK: begin
                        tag_reuse        <= 1'b0;
                        tag_bias_prev_sw <= 1'b0;
                        tag_ddr_pe_sw    <= 1'b0;
                        state            <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obuf_tag_req_arbiter.sv
// Directed self-checking bench for obuf_tag_req_arbiter (default round-robin build).
module tb_obuf_tag_req_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid, req_reuse, req_bias_prev_sw, req_ddr_pe_sw, req_block_done;
    logic [3:0] req_ack;
    logic [0:0] ack_tag;
    logic       tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw, block_done;
    logic       tag_ready;
    logic [0:0] tag;
    logic       busy;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    obuf_tag_req_arbiter #(
        .NUM_REQ  (4),
        .TAG_W    (1),
        .ISSUE_GAP(6)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_reuse       (req_reuse),
        .req_bias_prev_sw(req_bias_prev_sw),
        .req_ddr_pe_sw   (req_ddr_pe_sw),
        .req_block_done  (req_block_done),
        .req_ack         (req_ack),
        .ack_tag         (ack_tag),
        .tag_req         (tag_req),
        .tag_reuse       (tag_reuse),
        .tag_bias_prev_sw(tag_bias_prev_sw),
        .tag_ddr_pe_sw   (tag_ddr_pe_sw),
        .block_done      (block_done),
        .tag_ready       (tag_ready),
        .tag             (tag),
        .busy            (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 waits for tag_req, 1 waits for any req_ack; bounded by max_cyc.
    task automatic wait_evt(input int which, input int max_cyc, input string name);
        int n;
        n = 0;
        while (((which == 0) ? tag_req : (|req_ack)) !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(name, (which == 0) ? tag_req : (|req_ack), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [5];
        int t_req, t_prev, w, n_done;
        logic saw;
        order = '{0, 1, 2, 3, 0};
        t_prev = 0;

        reset = 1'b0;
        req_valid = '0; req_reuse = '0; req_bias_prev_sw = '0; req_ddr_pe_sw = '0;
        req_block_done = '0; tag_ready = 1'b0; tag = '0;
        step(2);
        chk("rst_req_ack", req_ack, 0);
        chk("rst_tag_req", tag_req, 0);
        chk("rst_block_done", block_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_attrs", {ack_tag, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw}, 0);

        // Single request from requester 1
        reset = 1'b1;
        step(1);
        req_valid = 4'b0010; req_reuse = 4'b0010; tag_ready = 1'b1; tag = 1'b1;
        step(1);
        chk("single_tag_req", tag_req, 1);
        chk("single_reuse", tag_reuse, 1);
        chk("single_bias", {tag_bias_prev_sw, tag_ddr_pe_sw}, 0);
        chk("single_busy", busy, 1);
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            saw = saw | tag_req | (|req_ack);
        end
        chk("single_gap_quiet", saw, 0);
        step(1);
        chk("single_ack", req_ack, 4'b0010);
        chk("single_ack_tag", ack_tag, 1);
        chk("single_reuse_held", tag_reuse, 1);
        req_valid = '0; req_reuse = '0;
        step(1);
        chk("single_idle", {busy, tag_req, req_ack, tag_reuse}, 0);

        // Round robin from a fresh pointer with all four held
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        req_valid = 4'b1111; req_reuse = 4'b0101; req_bias_prev_sw = 4'b0011;
        req_ddr_pe_sw = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            w = order[i];
            wait_evt(0, 12, "rr_tag_req");
            t_req = cyc;
            chk("rr_attrs", {tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw},
                {req_reuse[w], req_bias_prev_sw[w], req_ddr_pe_sw[w]});
            if (i > 0) chk("rr_spacing", t_req - t_prev, 8);
            t_prev = t_req;
            wait_evt(1, 12, "rr_ack_seen");
            chk("rr_ack_onehot", req_ack, 4'b0001 << w);
            chk("rr_ack_latency", cyc - t_req, 7);
            if (i == 4) req_valid = '0;
        end
        req_reuse = '0; req_bias_prev_sw = '0; req_ddr_pe_sw = '0;
        step(1);

        // Backpressure on requester 3
        tag_ready = 1'b0;
        req_valid = 4'b1000;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            saw = saw | tag_req;
        end
        chk("bp_no_tag_req", saw, 0);
        chk("bp_not_busy", busy, 0);
        tag_ready = 1'b1;
        step(1);
        chk("bp_issue_after_ready", tag_req, 1);
        tag_ready = 1'b0;
        step(7);
        chk("bp_ack", req_ack, 4'b1000);
        req_valid = '0; tag_ready = 1'b1;
        step(1);

        // block_done from requester 2 must precede requester 0's new issue
        req_valid = 4'b0100;
        step(1);
        chk("bd_tag_req", tag_req, 1);
        step(1);
        req_block_done = 4'b0100;
        step(1);
        req_block_done = '0;
        req_valid = 4'b0101;
        chk("bd_busy", busy, 1);
        step(5);
        chk("bd_ack2", req_ack, 4'b0100);
        req_valid = 4'b0001;
        step(1);
        chk("bd_idle_quiet", {block_done, tag_req}, 0);
        step(1);
        chk("bd_emit", {block_done, tag_req}, 2'b10);
        step(1);
        chk("bd_then_issue", {block_done, tag_req}, 2'b01);
        step(7);
        chk("bd_ack0", req_ack, 4'b0001);
        req_valid = '0;
        step(1);

        // Two block_done pulses for requester 1 merge into one
        req_valid = 4'b0010;
        step(1);
        chk("merge_tag_req", tag_req, 1);
        step(1);
        req_block_done = 4'b0010;
        step(1);
        req_block_done = '0;
        step(1);
        req_block_done = 4'b0010;
        step(1);
        req_block_done = '0;
        step(3);
        chk("merge_ack", req_ack, 4'b0010);
        req_valid = '0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (block_done === 1'b1) n_done++;
        end
        chk("merge_count", n_done, 1);
        chk("merge_idle", busy, 0);

        // Reset during GAP, then reissue from IDLE
        req_valid = 4'b0100; req_reuse = 4'b0100; tag = 1'b0;
        step(1);
        chk("mid_tag_req", {tag_req, tag_reuse}, 2'b11);
        step(2);
        #2 reset = 1'b0;
        #1 chk("mid_async_clear", {tag_reuse, busy, tag_req, req_ack}, 0);
        @(negedge clk);
        reset = 1'b1;
        step(1);
        chk("mid_reissue", {tag_req, tag_reuse}, 2'b11);
        step(6);
        tag = 1'b1;
        step(1);
        chk("mid_ack", req_ack, 4'b0100);
        chk("mid_ack_tag_sampled", ack_tag, 1);
        tag = 1'b0; req_valid = '0; req_reuse = '0;
        step(2);
        chk("mid_final_idle", busy, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
